// File: rtl/bcd_scan_display.sv
// bcd_scan_display
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display
//   showing MM:SS. The minute and second BCD counts are snapshotted once per
//   frame, so a count that changes mid-frame never tears the picture. The
//   seconds carry pulse toggles the colon dot. Any snapshot holding a non-BCD
//   field raises a sticky error flag.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous reset, active-low
//   en      display enable; when low the display blanks and all state holds
//   sec     seconds count, [6:4] tens (0-5), [3:0] ones (0-9)
//   min     minutes count, same format
//   sec_co  one-cycle carry pulse from the seconds counter (toggles colon)
//   an      digit enables, active-low; an[0]=sec ones ... an[3]=min tens
//   seg     segments, active-low, {g,f,e,d,c,b,a}
//   dp      decimal point, active-low; lit only on digit 2 (colon)
//   err     sticky invalid-BCD flag, cleared only by reset
module bcd_scan_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] sec,
  input  logic [6:0] min,
  input  logic       sec_co,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       err
);

  // A one-cycle dwell still needs a 1-bit counter to keep widths legal.
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       idx_reg, idx_next;
  logic [13:0]      snap_reg, snap_next;   // {min, sec}
  logic             dp_state_reg, dp_state_next;
  logic             err_reg, err_next;
  logic [3:0]       an_reg, an_next;
  logic [6:0]       seg_reg, seg_next;
  logic             dp_reg, dp_next;

  logic [3:0] digit [4];
  logic [3:0] digit_ok;

  // Active-low segment patterns; anything above 9 shows a dash.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  function automatic logic field_valid(input logic [6:0] f);
    return (f[3:0] <= 4'd9) && (f[6:4] <= 3'd5);
  endfunction

  // Split the snapshot into the four display digits. Even digits are ones
  // (0-9), odd digits are tens (0-5); tens 6/7 would otherwise decode as
  // legal numerals, hence the explicit per-digit range flag.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      localparam int BASE = 7 * (gi / 2);
      if (gi % 2 == 0) begin : g_ones
        assign digit[gi]    = snap_reg[BASE+3:BASE];
        assign digit_ok[gi] = (snap_reg[BASE+3:BASE] <= 4'd9);
      end else begin : g_tens
        assign digit[gi]    = {1'b0, snap_reg[BASE+6:BASE+4]};
        assign digit_ok[gi] = (snap_reg[BASE+6:BASE+4] <= 3'd5);
      end
    end
  endgenerate

  always_comb begin
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    snap_next     = snap_reg;
    dp_state_next = dp_state_reg;
    err_next      = err_reg;
    an_next       = 4'b1111;
    seg_next      = 7'h7F;
    dp_next       = 1'b1;

    if (en) begin
      // Outputs are built from pre-edge idx/snapshot, so they trail idx by one.
      an_next  = ~(4'b0001 << idx_reg);
      seg_next = digit_ok[idx_reg] ? seg7(digit[idx_reg]) : 7'h3F;
      dp_next  = ~((idx_reg == 2'd2) && dp_state_reg);

      if (cnt_reg == CNT_MAX) begin
        cnt_next = '0;
        idx_next = idx_reg + 2'd1;
        // Frame boundary: the only point where new counts are accepted.
        if (idx_reg == 2'd3) begin
          snap_next = {min, sec};
          if (!field_valid(min) || !field_valid(sec)) begin
            err_next = 1'b1;
          end
        end
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end

      if (sec_co) begin
        dp_state_next = ~dp_state_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg      <= '0;
      idx_reg      <= 2'd0;
      snap_reg     <= 14'd0;
      dp_state_reg <= 1'b0;
      err_reg      <= 1'b0;
      an_reg       <= 4'b1111;
      seg_reg      <= 7'h7F;
      dp_reg       <= 1'b1;
    end else begin
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      snap_reg     <= snap_next;
      dp_state_reg <= dp_state_next;
      err_reg      <= err_next;
      an_reg       <= an_next;
      seg_reg      <= seg_next;
      dp_reg       <= dp_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;
  assign err = err_reg;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display
//   Directed walk through reset, frame scanning, no-tearing, colon blink,
//   invalid BCD and pause, then a randomized run. Every edge is compared
//   against a reference model that tracks the position inside the frame as
//   a single enabled-cycle count and decodes digits arithmetically.
module tb_bcd_scan_display;

  localparam int SD = 4;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst, en, sec_co;
  logic [6:0] sec, min;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, err;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int         m_pos;        // enabled cycles into the current frame
  logic [6:0] m_snap_sec, m_snap_min;
  bit         m_dp, m_err;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_err;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bcd_scan_display #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .en(en), .sec(sec), .min(min), .sec_co(sec_co),
    .an(an), .seg(seg), .dp(dp), .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit valid(input logic [6:0] f);
    return (int'(f) % 16 <= 9) && (int'(f) / 16 <= 5);
  endfunction

  function automatic logic [6:0] exp_digit(input int d);
    int field, v, lim;
    field = (d < 2) ? int'(m_snap_sec) : int'(m_snap_min);
    v     = (d % 2 == 0) ? field % 16 : field / 16;
    lim   = (d % 2 == 0) ? 9 : 5;
    return (v > lim) ? 7'h3F : seg_tab[v];
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance model by one edge using the inputs currently driven, then
  // clock the DUT and compare all outputs.
  task automatic cycle();
    int d;
    if (!rst) begin
      m_pos = 0; m_snap_sec = 0; m_snap_min = 0; m_dp = 0; m_err = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else if (!en) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      d     = m_pos / SD;
      e_an  = 4'hF & ~(4'(1) << d);
      e_seg = exp_digit(d);
      e_dp  = !(d == 2 && m_dp);
      if (m_pos == FRAME - 1) begin
        m_snap_sec = sec;
        m_snap_min = min;
        if (!valid(sec) || !valid(min)) m_err = 1;
      end
      m_pos = (m_pos + 1) % FRAME;
      if (sec_co) m_dp = !m_dp;
    end
    e_err = m_err;
    @(posedge clk);
    #1;
    check("an",  {3'b0, an}, {3'b0, e_an});
    check("seg", seg, e_seg);
    check("dp",  {6'b0, dp}, {6'b0, e_dp});
    check("err", {6'b0, err}, {6'b0, e_err});
  endtask

  initial begin
    // Reset holds despite en and sec_co
    rst = 0; en = 1; sec_co = 1; sec = 7'h37; min = 7'h12;
    cycle(); cycle();
    check("rst_err0", {6'b0, err}, 7'd0);

    // Frame scan
    sec_co = 0; rst = 1;
    cycle();
    check("f1_an0", {3'b0, an}, 7'h0E);
    check("f1_seg0", seg, 7'h40);
    repeat (FRAME - 1) cycle();
    cycle();
    check("f2_seg0", seg, 7'h78);
    repeat (FRAME - 1) cycle();

    // No tearing: change inputs while digit 1 is showing
    repeat (SD + 1) cycle();
    sec = 7'h59;
    repeat (FRAME - SD - 1) cycle();
    repeat (FRAME) cycle();

    // Colon blink: single, second, and back-to-back pulses
    sec_co = 1; cycle(); sec_co = 0;
    repeat (FRAME) cycle();
    sec_co = 1; cycle(); sec_co = 0;
    repeat (FRAME) cycle();
    sec_co = 1; cycle(); cycle(); sec_co = 0;
    repeat (FRAME) cycle();

    // Invalid BCD, then recovery with sticky err
    sec = 7'h6A;
    repeat (2 * FRAME) cycle();
    check("err_set", {6'b0, err}, 7'd1);
    sec = 7'h00;
    repeat (2 * FRAME) cycle();
    check("err_sticky", {6'b0, err}, 7'd1);

    // Pause at cnt=2 of digit 1
    for (int i = 0; i < FRAME && m_pos != SD + 2; i++) cycle();
    check("pause_pos", 7'(m_pos), 7'(SD + 2));
    en = 0;
    repeat (3) cycle();
    check("pause_an", {3'b0, an}, 7'h0F);
    en = 1;
    cycle(); cycle();
    check("resume_an1", {3'b0, an}, 7'h0D);
    cycle();
    check("resume_an2", {3'b0, an}, 7'h0B);
    repeat (FRAME) cycle();

    // Mid-frame reset overrides en and sec_co
    rst = 0; sec_co = 1; cycle();
    rst = 1; sec_co = 0;
    repeat (FRAME) cycle();

    // Randomized run
    for (int i = 0; i < 800; i++) begin
      rst    = ($urandom_range(0, 99) != 0);
      en     = ($urandom_range(0, 9) != 0);
      sec_co = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 7) == 0) sec = 7'($urandom_range(0, 127));
        else sec = {3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        if ($urandom_range(0, 7) == 0) min = 7'($urandom_range(0, 127));
        else min = {3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed 4-digit 7-segment display driver for the MM:SS digital clock. It sits directly downstream of the two chained modulo-60 BCD counters (minutes and seconds). It snapshots their 7-bit BCD counts once per display frame and scans them onto a common-anode display. The seconds carry pulse blinks the colon dot. The block also flags any non-BCD count it receives.

## Interface
- SCAN_DIV, 4: clock cycles each digit stays lit; legal range ≥1. Use 50000 on the board and 4 in simulation.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  reset, synchronous and active-low. rst=0 at a clock edge resets the block.
- en  in  1  display enable; same meaning as the counter enable.
- sec  in  7  seconds BCD count: sec[6:4] tens (0–5), sec[3:0] ones (0–9).
- min  in  7  minutes BCD count, same format as sec.
- sec_co  in  1  one-cycle carry pulse from the seconds counter.
- an  out  4  digit enables, active-low. an[0]=sec ones, an[1]=sec tens, an[2]=min ones, an[3]=min tens.
- seg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low. Lit only on digit 2, forming the colon.
- err  out  1  sticky flag for an invalid BCD snapshot.

## Operation
- Internal state:
  - scan counter cnt, range 0..SCAN_DIV-1.
  - digit index idx, 2 bits.
  - 14-bit snapshot {min,sec}.
  - dp_state bit.
  - err bit.
- Reset (rst=0 at an edge):
  - cnt=0, idx=0, snapshot=0, dp_state=0, err=0.
  - an=4'b1111, seg=7'h7F, dp=1.
- en=0, rst=1:
  - cnt, idx, snapshot, dp_state and err hold; sec_co is ignored.
  - an<=4'b1111, seg<=7'h7F, dp<=1 (display blank).
- en=1, rst=1, on every edge:
  - an <= ~(4'b0001<<idx).
  - seg <= decode(digit idx of the snapshot).
  - dp <= ~(idx==2 && dp_state).
  - If cnt==SCAN_DIV-1: cnt<=0 and idx<=idx+1, wrapping 3→0. Otherwise cnt<=cnt+1.
  - Frame boundary (cnt==SCAN_DIV-1 && idx==3): snapshot<={min,sec}. If a loaded field is invalid, err<=1.
  - sec_co=1: dp_state<=~dp_state.
- Decode (active-low):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex).
  - A ones field >9 or a tens field >5 decodes as dash 7'h3F (g only), for that digit only.
- err clears only on reset.
- There is no leading-zero blanking; minute tens shows 0.

## Timing
- an, seg and dp are registered. They reflect idx and the snapshot as they were before the edge, so they lag idx by one cycle.
- Each digit stays lit for exactly SCAN_DIV consecutive enabled cycles. A frame is 4·SCAN_DIV enabled cycles.
- The first frame after reset always shows 00:00 because the snapshot is 0.
- An input change reaches the display at the first frame boundary after the change. The display is then updated from the next edge onward. The display never tears within a frame.
- sec_co is sampled every enabled cycle. Each pulse toggles dp_state exactly once. A pulse that coincides with a frame boundary or an idx advance still toggles.
- en dropping mid-digit blanks the outputs from the next edge. On re-enable, scanning resumes at the same idx with the remaining cnt, and the previous snapshot still applies.
- rst=0 asserted mid-frame produces the reset values on the next edge and overrides en and sec_co.
- SCAN_DIV=1: idx advances every enabled cycle, and every 4th enabled cycle is a frame boundary.

## Test plan
- **Reset:** drive rst=0 for 2 edges with en=1 and sec_co=1 → an=1111, seg=7F, dp=1, err=0.
- **Frame scan (SCAN_DIV=4):** set sec=7'h37, min=7'h12, then release reset with en=1.
  - Frame 1: seg=40 on an=1110, 1101, 1011, 0111, each held for 4 cycles.
  - Frame 2: an=1110/seg=78, then 1101/30, then 1011/24, then 0111/79.
- **No tearing:** change sec to 7'h59 during digit 1 of a frame → that frame still shows 7 and 3. The next frame shows 9 (seg=10) and 5 (seg=12).
- **Colon blink:** pulse sec_co for 1 cycle → dp=0 only during the an=1011 slots. A second pulse → dp stays 1. Two pulses on consecutive cycles → net no change.
- **Invalid BCD:** set sec=7'h6A → after the next frame boundary, digits 0 and 1 show 3F and err=1. Restoring sec=7'h00 → the display recovers but err stays 1 until rst=0.
- **Pause:** set en=0 at cnt=2, idx=1 → an=1111 from the next edge, with idx and cnt frozen. Restoring en=1 → an=1101 for exactly 2 more enabled cycles, then an=1011.
